// File: rtl/mux_rr_arbiter4_if.sv
// rtl/mux_rr_arbiter4_if.sv - requester/arbiter handshake bundle for one shared 32-bit resource port
interface mux_rr_arbiter4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    modport master (
        output req, done,
        input  grant, sel, busy, timeout
    );

    modport slave (
        input  req, done,
        output grant, sel, busy, timeout
    );
endinterface

// File: rtl/mux_rr_arbiter4.sv
// rtl/mux_rr_arbiter4.sv - 4-way round-robin arbiter with hold timeout driving a 4:1 datapath mux select
module mux_rr_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_rr_arbiter4_if.slave     bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    // A zero MAX_HOLD never matches because the compare is also gated below.
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       win;
    logic [1:0]       cand;
    logic             found;
    logic             hold_expired;

    always_comb begin
        win   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && bus.req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            hold_cnt    <= '0;
            bus.grant   <= 4'b0000;
            bus.sel     <= 2'd0;
            bus.busy    <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= BUSY;
                        bus.grant <= 4'b0001 << win;
                        bus.sel   <= win;
                        bus.busy  <= 1'b1;
                        hold_cnt  <= '0;
                        ptr       <= win + 2'd1;
                    end
                end
                BUSY: begin
                    // sel is left alone on release so the mux never glitches while idle.
                    if (bus.done || !bus.req[bus.sel]) begin
                        state     <= IDLE;
                        bus.grant <= 4'b0000;
                        bus.busy  <= 1'b0;
                    end else if (hold_expired) begin
                        state       <= IDLE;
                        bus.grant   <= 4'b0000;
                        bus.busy    <= 1'b0;
                        bus.timeout <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mux_rr_arbiter4.md
Name: mux_rr_arbiter4

Overview:
- Round-robin arbiter that shares one 32-bit 4:1-muxed resource port (e.g. a shared memory/writeback path) between four requesters.
- Produces a one-hot grant plus the 2-bit select that drives the 4:1 32-bit datapath mux.
- Holds ownership until the resource signals completion, the owner drops its request, or a hold timeout expires.
- Sits between the pipeline requesters and the mux select input; one instance per shared port.

Parameters:
- MAX_HOLD, 16, maximum cycles one owner may hold the grant. 0 disables the timeout.
- CNT_W, 5, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request per requester; bit i = requester i.
- done  input  1  resource finished the current owner's transfer; sampled only in BUSY.
- grant  output  4  one-hot grant, registered; all zero when idle.
- sel  output  2  binary index of the current or last owner; drives the 4:1 mux sel.
- busy  output  1  high while in BUSY.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold timeout.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values:
  - grant=0, sel=2'b00, busy=0, timeout=0.
  - Internal: priority pointer ptr=0, hold_cnt=0, state=IDLE.
  - rst mid-transfer drops the grant on the next edge with no timeout pulse.
- States: IDLE, BUSY.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, pick the winner w as the first set bit of req searched ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge: grant=onehot(w), sel=w, busy=1, hold_cnt=0, ptr=(w+1) mod 4, state=BUSY.
  - Latency: req assertion to grant is 1 cycle.
- BUSY (owner o = sel). Evaluate each cycle in this priority order:
  1. done==1: release. On the next edge grant=0, busy=0, state=IDLE.
  2. req[o]==0: release, same as done.
  3. MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: release and pulse timeout=1 for exactly the next cycle.
  4. Otherwise hold; hold_cnt increments by 1.
- done and timeout in the same cycle: treated as done, no timeout pulse.
- After any release there is one IDLE cycle before the next grant (re-arbitration cycle). Maximum grant rate is one grant every 2 cycles.
- sel keeps its last owner value while idle and changes only when a new grant is issued. This avoids mux glitching.
- Requests from non-owners during BUSY are ignored. They are serviced in round-robin order after release.
- ptr advances only on a grant, never on release, timeout or idle cycles.
- Fairness: any requester that holds req steady is granted within 4 arbitration rounds.
- grant is always one-hot or zero, and grant!=0 exactly when busy==1.
- All outputs come directly from registers; none are combinational from inputs.

Test Plan:
- Reset/idle: hold rst=1 for 2 cycles with req=4'b1111, then rst=0 -> while rst=1, grant=0, sel=0, busy=0. First grant appears 1 cycle after rst drops: grant=4'b0001, sel=0.
- Round-robin rotation: req=4'b1111 held constant, done pulsed on the 2nd BUSY cycle of each grant -> grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one idle cycle between grants.
- Pointer skip: after owner 1 releases, req=4'b0001 -> next grant=4'b0001, sel=0, and ptr becomes 1.
- Owner drop: grant=4'b0100, then req[2] deasserted with done=0 -> grant=0 next cycle, timeout stays 0, sel stays 2.
- Timeout: MAX_HOLD=4, req=4'b1000 held, done=0 -> grant=1000 for exactly 4 cycles, then grant=0 with timeout=1 for one cycle. The next grant is re-issued to 3 (the only requester) 1 cycle later.
- Simultaneous done/timeout and mid-transfer reset: with MAX_HOLD=4, assert done on hold_cnt=3 -> release with timeout=0. Separately, assert rst during BUSY -> next cycle grant=0, busy=0, ptr=0.
